// File: rtl/mux2_rr_arbiter.sv
// Two-input round-robin stream arbiter driving a registered 2:1 select stage with per-input grant counters.
// Latency: 1 cycle from accept to out_valid/out_data; sustains one word per cycle.
// Backpressure: inputs are accepted only when the output buffer is empty or draining (out_ready).
module mux2_rr_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    buf_state_t       state_q;
    buf_state_t       state_d;
    logic             last_grant_q;
    logic             load_en;
    logic             gnt_vld;
    logic             gnt_idx;
    logic             accept;
    logic [WIDTH-1:0] acc_data;

    assign out_valid = (state_q == BUF_FULL);
    assign load_en   = !out_valid || out_ready;

    // Contention goes to the input that did not win the last accepted transfer.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        if (in0_valid && in1_valid) begin
            gnt_vld = 1'b1;
            gnt_idx = !last_grant_q;
        end else if (in0_valid) begin
            gnt_vld = 1'b1;
            gnt_idx = 1'b0;
        end else if (in1_valid) begin
            gnt_vld = 1'b1;
            gnt_idx = 1'b1;
        end
    end

    assign accept    = rst_n && load_en && gnt_vld;
    assign in0_ready = accept && !gnt_idx;
    assign in1_ready = accept && gnt_idx;
    assign acc_data  = gnt_idx ? in1_data : in0_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: if (accept) state_d = BUF_FULL;
            BUF_FULL:  if (out_ready && !accept) state_d = BUF_EMPTY;
            default:   state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= BUF_EMPTY;
            out_data     <= '0;
            out_sel      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                out_data     <= acc_data;
                out_sel      <= gnt_idx;
                last_grant_q <= gnt_idx;
            end
        end
    end

    // Clear takes priority over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clear) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (in0_ready && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (in1_ready && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed vector table, corner sequences, random traffic against a reference model.
// A second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_mux2_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in0_valid, in1_valid, out_ready, cnt_clear;
    logic [3:0] in0_data, in1_data;

    logic       in0_ready, in1_ready, out_valid, out_sel;
    logic [3:0] out_data;
    logic [7:0] grant_cnt0, grant_cnt1;

    logic       s_in0_ready, s_in1_ready, s_out_valid, s_out_sel;
    logic [3:0] s_out_data;
    logic [1:0] s_grant_cnt0, s_grant_cnt1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready), .cnt_clear(cnt_clear),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    mux2_rr_arbiter #(.WIDTH(4), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(s_in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(s_in1_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_sel(s_out_sel),
        .out_ready(out_ready), .cnt_clear(cnt_clear),
        .grant_cnt0(s_grant_cnt0), .grant_cnt1(s_grant_cnt1)
    );

    // Reference model: buffer contents, priority pointer and counters as plain integers.
    bit       m_vld;
    bit [3:0] m_dat;
    int       m_sel, m_last;
    int       m_cnt[2];
    int       m_scnt[2];

    function automatic int model_grant();
        bit can_load;
        can_load = !m_vld || out_ready;
        if (!rst_n || !can_load) return -1;
        if (in0_valid && in1_valid) return (m_last == 0) ? 1 : 0;
        if (in0_valid) return 0;
        if (in1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        if (!rst_n) begin
            m_vld = 0; m_dat = 0; m_sel = 0; m_last = 1;
            m_cnt[0] = 0; m_cnt[1] = 0; m_scnt[0] = 0; m_scnt[1] = 0;
        end else begin
            g = model_grant();
            if (g >= 0) begin
                m_vld  = 1;
                m_dat  = (g == 1) ? in1_data : in0_data;
                m_sel  = g;
                m_last = g;
                if (m_cnt[g] < 255) m_cnt[g]++;
                if (m_scnt[g] < 3) m_scnt[g]++;
            end else if (out_ready) begin
                m_vld = 0;
            end
            if (cnt_clear) begin
                m_cnt[0] = 0; m_cnt[1] = 0; m_scnt[0] = 0; m_scnt[1] = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [3:0] d0, input logic v1,
                         input logic [3:0] d1, input logic ordy);
        in0_valid = v0; in0_data = d0;
        in1_valid = v1; in1_data = d1;
        out_ready = ordy;
    endtask

    typedef struct {
        logic       rst_n, v0;
        logic [3:0] d0;
        logic       v1;
        logic [3:0] d1;
        logic       ordy, clr;
        logic       e_r0, e_r1, e_ov;
        logic [3:0] e_od;
        logic       e_sel;
        logic [7:0] e_c0, e_c1;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int g;
        tbl[0] = '{1'b0, 1'b1, 4'h1, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 8'd0};
        tbl[1] = '{1'b1, 1'b1, 4'h1, 1'b1, 4'hE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 8'd0};
        tbl[2] = '{1'b1, 1'b1, 4'h1, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 8'd1, 8'd0};
        tbl[3] = '{1'b1, 1'b1, 4'h1, 1'b1, 4'hE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 1'b1, 8'd1, 8'd1};
        tbl[4] = '{1'b1, 1'b1, 4'h1, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 8'd2, 8'd1};
        tbl[5] = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hE, 1'b1, 8'd2, 8'd2};
        tbl[6] = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 1'b1, 8'd2, 8'd2};

        rst_n = 1'b0; cnt_clear = 1'b0;
        drive(1'b1, 4'h1, 1'b1, 4'hE, 1'b1);
        tick();

        // Reset hold and alternation
        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; cnt_clear = tbl[i].clr;
            drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].ordy);
            @(negedge clk);
            chk($sformatf("tbl%0d in0_ready", i), in0_ready, tbl[i].e_r0);
            chk($sformatf("tbl%0d in1_ready", i), in1_ready, tbl[i].e_r1);
            chk($sformatf("tbl%0d out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d out_data", i), out_data, tbl[i].e_od);
            chk($sformatf("tbl%0d out_sel", i), out_sel, tbl[i].e_sel);
            chk($sformatf("tbl%0d grant_cnt0", i), grant_cnt0, tbl[i].e_c0);
            chk($sformatf("tbl%0d grant_cnt1", i), grant_cnt1, tbl[i].e_c1);
            tick();
        end

        // Backpressure holds the buffered word
        drive(1'b1, 4'hA, 1'b0, 4'h0, 1'b1);
        @(negedge clk); chk("bp load in0_ready", in0_ready, 1);
        tick();
        drive(1'b0, 4'h0, 1'b1, 4'h5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp in1_ready", in1_ready, 0);
            chk("bp out_valid", out_valid, 1);
            chk("bp out_data", out_data, 4'hA);
            chk("bp out_sel", out_sel, 0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk); chk("bp release in1_ready", in1_ready, 1);
        tick();
        in1_valid = 1'b0;
        @(negedge clk);
        chk("bp next out_data", out_data, 4'h5);
        chk("bp next out_sel", out_sel, 1);
        chk("bp next out_valid", out_valid, 1);

        // Single requester wins every cycle
        cnt_clear = 1'b1; drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        tick();
        cnt_clear = 1'b0; drive(1'b0, 4'h0, 1'b1, 4'h3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("single in1_ready", in1_ready, 1);
            chk("single in0_ready", in0_ready, 0);
            if (i > 0) chk("single out_sel", out_sel, 1);
            tick();
        end
        in1_valid = 1'b0;
        @(negedge clk);
        chk("single out_data", out_data, 4'h3);
        chk("single grant_cnt1", grant_cnt1, 5);
        chk("single grant_cnt0", grant_cnt0, 0);
        chk("single small grant_cnt1 saturated", s_grant_cnt1, 3);

        // Saturation, then clear beating a same-cycle increment
        cnt_clear = 1'b1; tick();
        cnt_clear = 1'b0; drive(1'b1, 4'h7, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("sat in0_ready", s_in0_ready, 1);
            tick();
        end
        @(negedge clk);
        chk("sat small grant_cnt0", s_grant_cnt0, 3);
        chk("sat wide grant_cnt0", grant_cnt0, 5);
        cnt_clear = 1'b1;
        @(negedge clk); chk("clr accept in0_ready", in0_ready, 1);
        tick();
        cnt_clear = 1'b0; in0_valid = 1'b0;
        @(negedge clk);
        chk("clr small grant_cnt0", s_grant_cnt0, 0);
        chk("clr wide grant_cnt0", grant_cnt0, 0);
        chk("clr out_data", out_data, 4'h7);

        // Reset while full drops the word and restores in0 priority
        drive(1'b1, 4'hC, 1'b0, 4'h0, 1'b1);
        tick();
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        chk("rst-mid out_valid before", out_valid, 1);
        chk("rst-mid out_data before", out_data, 4'hC);
        rst_n = 1'b0; tick();
        rst_n = 1'b1; drive(1'b1, 4'h2, 1'b1, 4'h9, 1'b1);
        @(negedge clk);
        chk("rst-mid out_valid", out_valid, 0);
        chk("rst-mid grant_cnt0", grant_cnt0, 0);
        chk("rst-mid in0_ready", in0_ready, 1);
        chk("rst-mid in1_ready", in1_ready, 0);
        tick();
        @(negedge clk);
        chk("rst-mid first out_data", out_data, 4'h2);
        chk("rst-mid first out_sel", out_sel, 0);

        // Random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(63) != 0);
            cnt_clear = ($urandom_range(15) == 0);
            drive($urandom_range(3) != 0, 4'($urandom), $urandom_range(3) != 0,
                  4'($urandom), $urandom_range(2) != 0);
            @(negedge clk);
            g = model_grant();
            chk("rnd in0_ready", in0_ready, g == 0);
            chk("rnd in1_ready", in1_ready, g == 1);
            chk("rnd out_valid", out_valid, m_vld);
            if (m_vld) begin
                chk("rnd out_data", out_data, m_dat);
                chk("rnd out_sel", out_sel, m_sel);
            end
            chk("rnd grant_cnt0", grant_cnt0, m_cnt[0]);
            chk("rnd grant_cnt1", grant_cnt1, m_cnt[1]);
            chk("rnd small grant_cnt0", s_grant_cnt0, m_scnt[0]);
            chk("rnd small grant_cnt1", s_grant_cnt1, m_scnt[1]);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
